// File: rtl/inst_fetch_if.sv
// Instruction-memory AXI4-Lite read channel (AR + R only) between the fetch
// stage and the instruction memory.
//
// Handshake rule for both channels: a beat transfers on the rising clock
// edge where valid and ready are both 1. The source holds valid and its
// payload (araddr/arprot, or rdata/rresp) stable from the moment valid rises
// until that edge, and it never drops valid before the transfer. The sink may
// raise or lower ready freely.
interface inst_fetch_if;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic [2:0]  mem_arprot;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;

    modport master (
        output mem_arvalid, mem_araddr, mem_arprot, mem_rready,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );

    modport slave (
        input  mem_arvalid, mem_araddr, mem_arprot, mem_rready,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one AXI4-Lite read per instruction at the current
// pc. The returned word is held with inst_valid until enable_pc retires it.
// A misaligned pc or an error response substitutes NOP_INST and raises
// fetch_err. Every output is registered.
// Optional feature: define INST_FETCH_STALL_CNT_EN to build the memory-wait
// cycle counter on stall_cnt; otherwise stall_cnt is tied to zero.
// fsm_state exposes the FSM state (0 LAUNCH, 1 ADDR, 2 DATA, 3 HOLD).
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                enable_pc,
    inst_fetch_if.master        mem,
    output logic [31:0]         inst,
    output logic                inst_valid,
    output logic                fetch_err,
    output logic [31:0]         stall_cnt,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        LAUNCH = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_n;
    logic        arvalid_q, arvalid_n;
    logic [31:0] araddr_q, araddr_n;
    logic        rready_q, rready_n;
    logic [31:0] inst_q, inst_n;
    logic        inst_valid_q, inst_valid_n;
    logic        fetch_err_q, fetch_err_n;

    // Next state plus next value of every registered output; each output
    // therefore changes exactly on the edge where the state does.
    always_comb begin
        state_n      = state_q;
        arvalid_n    = arvalid_q;
        araddr_n     = araddr_q;
        rready_n     = rready_q;
        inst_n       = inst_q;
        inst_valid_n = inst_valid_q;
        fetch_err_n  = fetch_err_q;
        case (state_q)
            LAUNCH: begin
                // pc already reflects the retire edge that brought us here.
                araddr_n = pc;
                if (pc[1:0] != 2'b00) begin
                    // Misaligned: never touch the bus, hand out a NOP.
                    state_n      = HOLD;
                    inst_n       = NOP_INST;
                    fetch_err_n  = 1'b1;
                    inst_valid_n = 1'b1;
                end else begin
                    state_n   = ADDR;
                    arvalid_n = 1'b1;
                end
            end
            ADDR: begin
                if (mem.mem_arready) begin
                    state_n   = DATA;
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end
            end
            DATA: begin
                if (mem.mem_rvalid) begin
                    state_n      = HOLD;
                    rready_n     = 1'b0;
                    inst_valid_n = 1'b1;
                    if (mem.mem_rresp == 2'b00) begin
                        inst_n      = mem.mem_rdata;
                        fetch_err_n = 1'b0;
                    end else begin
                        inst_n      = NOP_INST;
                        fetch_err_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                // inst/fetch_err stay frozen; only retirement leaves HOLD.
                if (enable_pc) begin
                    state_n      = LAUNCH;
                    inst_valid_n = 1'b0;
                end
            end
            default: begin
                state_n = LAUNCH;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LAUNCH;
            arvalid_q    <= 1'b0;
            araddr_q     <= 32'h0;
            rready_q     <= 1'b0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            arvalid_q    <= arvalid_n;
            araddr_q     <= araddr_n;
            rready_q     <= rready_n;
            inst_q       <= inst_n;
            inst_valid_q <= inst_valid_n;
            fetch_err_q  <= fetch_err_n;
        end
    end

`ifdef INST_FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count every cycle the memory makes us wait; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if ((state_q == ADDR && !mem.mem_arready) ||
                     (state_q == DATA && !mem.mem_rvalid)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

    assign mem.mem_arvalid = arvalid_q;
    assign mem.mem_araddr  = araddr_q;
    assign mem.mem_arprot  = 3'b100;
    assign mem.mem_rready  = rready_q;
    assign inst            = inst_q;
    assign inst_valid      = inst_valid_q;
    assign fetch_err       = fetch_err_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench plays the utility block (pc,
// enable_pc) and a scripted AXI4-Lite memory slave with per-fetch wait states.
// Inputs change and outputs are sampled on the falling edge.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        enable_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic [31:0] stall_cnt;
    logic [1:0]  fsm_state;

    inst_fetch_if mem_bus ();

    inst_fetch #(.NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .enable_pc  (enable_pc),
        .mem        (mem_bus),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .stall_cnt  (stall_cnt),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    // enable_pc outside HOLD is a protocol violation; tallied, not fatal.
    int viol = 0;
    always @(posedge clk) begin
        if (!rst && enable_pc && !inst_valid) begin
            viol <= viol + 1;
            $display("note: enable_pc asserted outside HOLD at cycle %0d", cyc);
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          stall_model = 0;
    int          t0;
    int          ar_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef INST_FETCH_STALL_CNT_EN
        return stall_model;
`else
        return 32'h0;
`endif
    endfunction

    // Cycle number (1 = first cycle after the reference edge) of "now".
    function automatic logic [31:0] cyc_num();
        return cyc - t0 + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_arvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_bus.mem_arvalid) begin
                ok = 1'b1;
                ar_seen = cyc_num();
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check_val("arvalid_timeout", 32'd0, 32'd1);
    endtask

    // Memory slave: ar_wait cycles before arready, r_wait cycles before rvalid.
    task automatic serve(input int ar_wait, input int r_wait, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input logic [1:0] rresp);
        bit ok;
        wait_arvalid(ok);
        if (ok) begin
            check_val("araddr", mem_bus.mem_araddr, exp_addr);
            check_val("arprot", {29'd0, mem_bus.mem_arprot}, 32'd4);
            for (int i = 0; i < ar_wait; i++) begin
                mem_bus.mem_arready = 1'b0;
                @(negedge clk);
                check_val("arvalid_hold", {31'd0, mem_bus.mem_arvalid}, 32'd1);
                check_val("araddr_hold", mem_bus.mem_araddr, exp_addr);
            end
            mem_bus.mem_arready = 1'b1;
            @(negedge clk);
            mem_bus.mem_arready = 1'b0;
            check_val("arvalid_drop", {31'd0, mem_bus.mem_arvalid}, 32'd0);
            check_val("rready", {31'd0, mem_bus.mem_rready}, 32'd1);
            for (int i = 0; i < r_wait; i++) begin
                @(negedge clk);
                check_val("rready_hold", {31'd0, mem_bus.mem_rready}, 32'd1);
            end
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = rdata;
            mem_bus.mem_rresp  = rresp;
            @(negedge clk);
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = 32'h0;
            mem_bus.mem_rresp  = 2'b00;
            stall_model += ar_wait + r_wait;
        end
    endtask

    // Retire the held word; pc moves on the retire edge like the utility block.
    task automatic retire(input logic [31:0] new_pc);
        enable_pc = 1'b1;
        @(posedge clk);
        #1;
        pc = new_pc;
        enable_pc = 1'b0;
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic check_hold(input string tag, input logic exp_err);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check_val({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check_val({tag, "_inst"}, inst, e);
        check_val({tag, "_err"}, {31'd0, fetch_err}, {31'd0, exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_arvalid"}, {31'd0, mem_bus.mem_arvalid}, 32'd0);
        check_val({tag, "_araddr"}, mem_bus.mem_araddr, 32'd0);
        check_val({tag, "_rready"}, {31'd0, mem_bus.mem_rready}, 32'd0);
        check_val({tag, "_inst"}, inst, 32'd0);
        check_val({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check_val({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        check_val({tag, "_stall"}, stall_cnt, 32'd0);
        check_val({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        rst = 1'b1;
        pc = 32'h0;
        enable_pc = 1'b0;
        mem_bus.mem_arready = 1'b0;
        mem_bus.mem_rvalid  = 1'b0;
        mem_bus.mem_rdata   = 32'h0;
        mem_bus.mem_rresp   = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // 1: zero-wait fetch at pc=0, then retire and fetch pc=4.
        rst = 1'b0;
        t0 = cyc;
        exp_q.push_back(32'h00500093);
        serve(0, 0, 32'h0, 32'h00500093, 2'b00);
        check_val("first_arvalid_cycle", ar_seen, 32'd2);
        check_hold("t1a", 1'b0);
        @(negedge clk);
        check_val("t1a_inst_stable", inst, 32'h00500093);
        check_val("t1a_valid_stable", {31'd0, inst_valid}, 32'd1);
        retire(32'h4);
        check_val("t1_valid_drop", {31'd0, inst_valid}, 32'd0);
        exp_q.push_back(32'h00100113);
        serve(0, 0, 32'h4, 32'h00100113, 2'b00);
        check_val("t1_latency", cyc_num(), 32'd4);
        check_hold("t1b", 1'b0);

        // 2: 3 address wait cycles and 2 data wait cycles.
        retire(32'h8);
        exp_q.push_back(32'h00208193);
        serve(3, 2, 32'h8, 32'h00208193, 2'b00);
        check_val("t2_latency", cyc_num(), 32'd9);
        check_hold("t2", 1'b0);
        check_val("t2_stall", stall_cnt, exp_stall());

        // 3: misaligned pc, no bus traffic.
        retire(32'h00000102);
        check_val("t3_c1_arvalid", {31'd0, mem_bus.mem_arvalid}, 32'd0);
        check_val("t3_c1_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check_val("t3_c2_arvalid", {31'd0, mem_bus.mem_arvalid}, 32'd0);
        check_val("t3_araddr", mem_bus.mem_araddr, 32'h00000102);
        exp_q.push_back(NOP);
        check_hold("t3", 1'b1);
        @(negedge clk);
        check_val("t3_c3_arvalid", {31'd0, mem_bus.mem_arvalid}, 32'd0);

        // 4: SLVERR response substitutes a NOP; next clean fetch clears the error.
        retire(32'h10C);
        exp_q.push_back(NOP);
        serve(0, 0, 32'h10C, 32'hDEADBEEF, 2'b10);
        check_hold("t4_err", 1'b1);
        retire(32'h110);
        exp_q.push_back(32'h00000033);
        serve(1, 0, 32'h110, 32'h00000033, 2'b00);
        check_hold("t4_clean", 1'b0);
        check_val("t4_stall", stall_cnt, exp_stall());

        // 5: reset in DATA with a read beat pending.
        retire(32'h114);
        wait_arvalid(ok);
        mem_bus.mem_arready = 1'b1;
        @(negedge clk);
        mem_bus.mem_arready = 1'b0;
        check_val("t5_in_data", {30'd0, fsm_state}, 32'd2);
        rst = 1'b1;
        pc = 32'h0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        stall_model = 0;
        t0 = cyc;
        exp_q.push_back(32'h00500093);
        serve(0, 0, 32'h0, 32'h00500093, 2'b00);
        check_val("t5_latency", cyc_num(), 32'd4);
        check_hold("t5", 1'b0);

        // 6: enable_pc pulsed during ADDR is ignored.
        retire(32'h20);
        wait_arvalid(ok);
        enable_pc = 1'b1;
        @(negedge clk);
        enable_pc = 1'b0;
        stall_model += 1;
        check_val("t6_state", {30'd0, fsm_state}, 32'd1);
        check_val("t6_arvalid", {31'd0, mem_bus.mem_arvalid}, 32'd1);
        check_val("t6_valid", {31'd0, inst_valid}, 32'd0);
        check_val("t6_araddr", mem_bus.mem_araddr, 32'h20);
        exp_q.push_back(32'h002081b3);
        serve(0, 0, 32'h20, 32'h002081b3, 2'b00);
        check_val("t6_latency", cyc_num(), 32'd5);
        check_hold("t6", 1'b0);
        check_val("t6_stall", stall_cnt, exp_stall());
        check_val("t6_violations", viol, 32'd1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the mriscvcore. It sits directly upstream of the decoder and downstream of the PC/utility block. It reads the current `pc` and issues one AXI4-Lite read per instruction on the instruction memory port. It then holds the returned word with `inst_valid` until the core retires it via `enable_pc`, which is the same strobe that advances the PC.

## Interface
- `NOP_INST`, default 32'h00000013: word substituted on fetch error (ADDI x0,x0,0).
- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  current PC from the utility block; it updates on the edge where `enable_pc`=1.
- `enable_pc`  in  1  retire strobe; the held instruction is consumed.
- `mem_arvalid`  out  1  AXI read address valid.
- `mem_araddr`  out  32  AXI read address.
- `mem_arprot`  out  3  constant 3'b100 (instruction access).
- `mem_arready`  in  1  AXI read address ready.
- `mem_rvalid`  in  1  AXI read data valid.
- `mem_rdata`  in  32  AXI read data.
- `mem_rresp`  in  2  AXI read response.
- `mem_rready`  out  1  AXI read data ready.
- `inst`  out  32  instruction to the decoder.
- `inst_valid`  out  1  `inst` is valid and stable.
- `fetch_err`  out  1  current `inst` is a substitute caused by a misaligned PC or a bus error.
- `stall_cnt`  out  32  memory-wait cycle counter (see Configuration).

## Operation
- FSM states: LAUNCH, ADDR, DATA, HOLD.
- **Reset.** State goes to LAUNCH.
  - `mem_arvalid`=0, `mem_rready`=0, `mem_araddr`=0.
  - `inst`=0, `inst_valid`=0, `fetch_err`=0, `stall_cnt`=0.
- **LAUNCH** (one cycle). Register `pc` into `mem_araddr`.
  - If `pc[1:0]`≠0, go to HOLD with `inst`=NOP_INST and `fetch_err`=1. No bus access is made.
  - Otherwise go to ADDR.
- **ADDR.** `mem_arvalid`=1; `mem_araddr` is held stable.
  - On `mem_arready`=1, go to DATA.
  - `mem_arvalid` never drops before the handshake.
- **DATA.** `mem_rready`=1.
  - On `mem_rvalid`=1, go to HOLD.
  - If `mem_rresp`=2'b00: `inst`=`mem_rdata`, `fetch_err`=0.
  - Otherwise: `inst`=NOP_INST, `fetch_err`=1.
- **HOLD.** `inst_valid`=1; `inst` and `fetch_err` are frozen.
  - On `enable_pc`=1, deassert `inst_valid` at the next edge and go to LAUNCH.
  - LAUNCH samples the already-updated `pc`.
- `enable_pc` asserted outside HOLD is ignored. The bench flags it as a protocol violation.
- Only one read is outstanding at any time. No prefetch, no buffering beyond one word.
- Interrupt redirection needs no handling here: the utility block loads `irr_dest` into `pc` on the retire edge, and LAUNCH picks it up.
- **Reset mid-transaction.** Any state returns to LAUNCH, and all outputs take their reset values the following cycle. The memory slave shares `rst`, so no stale beat is expected.

## Timing
- Best case, retire to next valid: `enable_pc` at edge E0, LAUNCH during cycle 1, ADDR with `mem_arready`=1 in cycle 2, DATA with `mem_rvalid`=1 in cycle 3. `inst_valid`=1 from cycle 4, i.e. 4 cycles.
- Each wait cycle in ADDR or DATA adds one cycle.
- Misaligned PC: `inst_valid` 2 cycles after the LAUNCH entry edge.
- After reset release, the first `mem_arvalid` rises in cycle 2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `INST_FETCH_STALL_CNT_EN`.
- **Defined:** `stall_cnt` is a 32-bit counter.
  - It increments on every cycle in ADDR with `mem_arready`=0, and on every cycle in DATA with `mem_rvalid`=0.
  - It wraps from 32'hFFFFFFFF to 0.
  - It is cleared only by `rst`.
- **Undefined:** no counter logic; `stall_cnt` is tied to 32'h0.

## Test plan
- Zero-wait memory returning 32'h00500093 at `pc`=0, with `enable_pc` pulsed 1 cycle after `inst_valid` → `mem_araddr`=0, `inst`=32'h00500093, `fetch_err`=0. Next fetch uses the updated `pc`=4, and `inst_valid` reasserts exactly 4 cycles after the retire edge.
- `mem_arready` delayed 3 cycles and `mem_rvalid` delayed 2 cycles → `mem_arvalid`/`mem_araddr` stable throughout, `inst_valid` 5 cycles later than best case, `stall_cnt`=5 with the macro defined and 0 without it.
- `pc`=32'h00000102 → no `mem_arvalid` pulse, `inst`=32'h00000013, `fetch_err`=1, `inst_valid`=1 two cycles after LAUNCH entry.
- `mem_rresp`=2'b10 with `mem_rdata`=32'hDEADBEEF → `inst`=32'h00000013, `fetch_err`=1; the next clean fetch clears `fetch_err`.
- `rst` asserted in DATA with `mem_rvalid` pending → next cycle all outputs are 0 and the FSM is in LAUNCH; a fresh fetch of `pc`=0 completes normally.
- `enable_pc` pulsed while in ADDR → ignored: no state change, `inst_valid` unaffected, and the next fetch proceeds unchanged.
